// File: rtl/int_controller.sv
// ---------------------------------------------------------------------------
// int_controller
// Prioritised interrupt controller for NUM_CH sources. Each channel is either
// edge- or level-sensitive (MODE), can be masked (MASK), and holds a pending
// bit that software can clear with write-1-to-clear (PENDING). The lowest
// numbered pending and unmasked channel is presented to the CPU as a vector
// through a three-state handshake: IDLE -> REQ (int_rq high) -> SERVICE.
//
// Optional build macro: INT_CTRL_SYNC_EN
//   defined   : irq_in passes a two-flop synchroniser before edge detection
//               (request latency grows by two clocks).
//   undefined : irq_in is used directly and must be synchronous to clk.
// ---------------------------------------------------------------------------
module int_controller #(
    parameter int NUM_CH = 8,
    parameter int VEC_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              int_inhibit,
    input  logic              int_ack,
    input  logic              int_done,
    input  logic              cfg_wren,
    input  logic [1:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic [15:0]       cfg_rdata,
    output logic              int_rq,
    output logic [VEC_W-1:0]  int_addr
);

    // Register map
    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Lowest set index of a channel vector; channel 0 has the highest priority.
    function automatic logic [VEC_W-1:0] lowest_index(input logic [NUM_CH-1:0] vec);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = VEC_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              r_state;
    logic                r_int_rq;
    logic [VEC_W-1:0]    r_int_addr;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_mode;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_irq_prev;

    logic [NUM_CH-1:0]   w_irq_s;
    logic [NUM_CH-1:0]   w_edge;
    logic [NUM_CH-1:0]   w_w1c_clr;
    logic [NUM_CH-1:0]   w_ack_clr;
    logic [NUM_CH-1:0]   w_pending_next;
    logic [NUM_CH-1:0]   w_cand;
    logic [VEC_W-1:0]    w_winner;
    logic [15:0]         w_rdata;
    logic                w_wr_mask;
    logic                w_wr_mode;
    logic                w_wr_pending;

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_CH-1:0]   r_sync1;
    logic [NUM_CH-1:0]   r_sync2;

    // Two-flop synchroniser for asynchronous interrupt sources
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_s = r_sync2;
`else
    assign w_irq_s = irq_in;
`endif

    // Previous sample of the sources. Resetting to ones means a source that is
    // already high when reset is released is not mistaken for a new edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_prev <= '1;
        end else begin
            r_irq_prev <= w_irq_s;
        end
    end

    assign w_edge       = w_irq_s & ~r_irq_prev;
    assign w_wr_mask    = cfg_wren && (cfg_addr == ADDR_MASK);
    assign w_wr_mode    = cfg_wren && (cfg_addr == ADDR_MODE);
    assign w_wr_pending = cfg_wren && (cfg_addr == ADDR_PENDING);
    assign w_w1c_clr    = w_wr_pending ? cfg_wdata[NUM_CH-1:0] : '0;

    // One-hot clear of the channel being acknowledged by the CPU
    always_comb begin
        w_ack_clr = '0;
        if ((r_state == ST_REQ) && int_ack) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (VEC_W'(i) == r_int_addr) begin
                    w_ack_clr[i] = 1'b1;
                end else begin
                    w_ack_clr[i] = 1'b0;
                end
            end
        end else begin
            w_ack_clr = '0;
        end
    end

    // Level channels follow the source; edge channels set on a rising edge
    // (a set always beats a W1C or acknowledge clear on the same edge).
    assign w_pending_next = (r_mode & w_irq_s)
                          | (~r_mode & (w_edge | (r_pending & ~(w_w1c_clr | w_ack_clr))));

    assign w_cand   = r_pending & r_mask;
    assign w_winner = lowest_index(w_cand);

    // Configuration registers and pending flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask    <= '0;
            r_mode    <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_wr_mask) begin
                r_mask <= cfg_wdata[NUM_CH-1:0];
            end else begin
                r_mask <= r_mask;
            end
            if (w_wr_mode) begin
                r_mode <= cfg_wdata[NUM_CH-1:0];
            end else begin
                r_mode <= r_mode;
            end
        end
    end

    // Request handshake FSM; int_rq and int_addr are held stable while in REQ
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_int_rq   <= 1'b0;
            r_int_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((|w_cand) && !int_inhibit) begin
                        r_state    <= ST_REQ;
                        r_int_rq   <= 1'b1;
                        r_int_addr <= w_winner;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_int_rq   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        r_state  <= ST_SERVICE;
                        r_int_rq <= 1'b0;
                    end else begin
                        r_state  <= ST_REQ;
                        r_int_rq <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    r_int_rq <= 1'b0;
                    if (int_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SERVICE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_int_rq <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register read-back; unused bits read as zero
    always_comb begin
        w_rdata = 16'd0;
        case (cfg_addr)
            ADDR_MASK:    w_rdata[NUM_CH-1:0] = r_mask;
            ADDR_MODE:    w_rdata[NUM_CH-1:0] = r_mode;
            ADDR_PENDING: w_rdata[NUM_CH-1:0] = r_pending;
            ADDR_STATUS: begin
                w_rdata[0]           = (r_state == ST_SERVICE);
                w_rdata[1]           = (r_state == ST_REQ);
                w_rdata[VEC_W+3:4]   = r_int_addr;
            end
            default:      w_rdata = 16'd0;
        endcase
    end

    assign cfg_rdata = w_rdata;
    assign int_rq    = r_int_rq;
    assign int_addr  = r_int_addr;

endmodule

// File: tb/tb_int_controller.sv
// ---------------------------------------------------------------------------
// tb_int_controller
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the controller's rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_int_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        int_inhibit, int_ack, int_done, cfg_wren;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        int_rq;
    logic [3:0]  int_addr;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0] m_pend, m_mask, m_mode, m_prev, m_s1, m_s2;
    int         m_state;   // 0 idle, 1 request, 2 service
    int         m_addr;

    int_controller #(.NUM_CH(8), .VEC_W(4)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .int_inhibit(int_inhibit),
        .int_ack(int_ack), .int_done(int_done), .cfg_wren(cfg_wren),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .int_rq(int_rq), .int_addr(int_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] a);
        logic [15:0] v;
        v = 16'd0;
        case (a)
            2'd0: v[7:0] = m_mask;
            2'd1: v[7:0] = m_mode;
            2'd2: v[7:0] = m_pend;
            default: begin
                v[0]   = (m_state == 2);
                v[1]   = (m_state == 1);
                v[7:4] = 4'(m_addr);
            end
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'h00;
        m_prev = 8'hFF; m_s1 = 8'h00; m_s2 = 8'h00;
        m_state = 0; m_addr = 0;
    endtask

    // One clock: predict from current inputs, clock the DUT, compare.
    task automatic step();
        logic [7:0] s, e, np, nmask, nmode;
        int ns, na;
`ifdef INT_CTRL_SYNC_EN
        s = m_s2;
`else
        s = irq_in;
`endif
        e = s & ~m_prev;
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i])
                np[i] = s[i];
            else if (e[i])
                np[i] = 1'b1;
            else if ((cfg_wren && cfg_addr == 2'd2 && cfg_wdata[i]) ||
                     (m_state == 1 && int_ack && m_addr == i))
                np[i] = 1'b0;
            else
                np[i] = m_pend[i];
        end
        nmask = (cfg_wren && cfg_addr == 2'd0) ? cfg_wdata[7:0] : m_mask;
        nmode = (cfg_wren && cfg_addr == 2'd1) ? cfg_wdata[7:0] : m_mode;
        ns = m_state; na = m_addr;
        if (m_state == 0) begin
            if ((m_pend & m_mask) != 8'h00 && !int_inhibit) begin
                ns = 1;
                for (int i = 7; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) na = i;
            end
        end else if (m_state == 1) begin
            if (int_ack) ns = 2;
        end else begin
            if (int_done) ns = 0;
        end
        @(posedge clk);
        #1;
        m_s2 = m_s1; m_s1 = irq_in; m_prev = s;
        m_pend = np; m_mask = nmask; m_mode = nmode; m_state = ns; m_addr = na;
        chk("int_rq", {15'd0, int_rq}, {15'd0, m_state == 1});
        chk("int_addr", {12'd0, int_addr}, 16'(m_addr));
        chk("cfg_rdata", cfg_rdata, model_read(cfg_addr));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_wren = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_wren = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; step(); int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1; step(); int_done = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [15:0] d);
        cfg_addr = a; #1; d = cfg_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_rq", {15'd0, int_rq}, 16'd0);
        chk("rst_addr", {12'd0, int_addr}, 16'd0);
        model_reset();
        int_ack = 1'b0; int_done = 1'b0; cfg_wren = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [15:0] rd;
    int lat;

    initial begin
        reset = 1'b1; irq_in = 8'h00; int_inhibit = 1'b0; int_ack = 1'b0;
        int_done = 1'b0; cfg_wren = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'd0;
        model_reset();
        #12;
        do_reset();
        peek(2'd3, rd); chk("rst_status", rd, 16'h0000);
        peek(2'd2, rd); chk("rst_pending", rd, 16'h0000);

        // Single channel round trip with latency check
        wr(2'd0, 16'hFFFF);
        peek(2'd0, rd); chk("mask_wide", rd, 16'h00FF);
        irq_in[5] = 1'b1;
        step();
        chk("c5_lat0", {15'd0, int_rq}, 16'd0);
        step();
        chk("c5_rq", {15'd0, int_rq}, 16'd1);
        chk("c5_vec", {12'd0, int_addr}, 16'd5);
        pulse_ack();
        peek(2'd2, rd); chk("c5_pend_clr", rd, 16'h0000);
        peek(2'd3, rd); chk("c5_status_svc", rd, 16'h0051);
        pulse_done();
        peek(2'd3, rd); chk("c5_status_idle", rd, 16'h0050);
        irq_in = 8'h00; steps(2);

        // Priority between two simultaneous edges, with a gap between requests
        irq_in[2] = 1'b1; irq_in[6] = 1'b1;
        steps(2);
        chk("pri_first", {12'd0, int_addr}, 16'd2);
        pulse_ack();
        pulse_done();
        chk("pri_gap", {15'd0, int_rq}, 16'd0);
        step();
        chk("pri_second_rq", {15'd0, int_rq}, 16'd1);
        chk("pri_second", {12'd0, int_addr}, 16'd6);
        pulse_ack(); pulse_done();
        irq_in = 8'h00; steps(2);

        // Inhibit holds off the request
        int_inhibit = 1'b1;
        irq_in[3] = 1'b1;
        steps(4);
        chk("inh_hold", {15'd0, int_rq}, 16'd0);
        int_inhibit = 1'b0;
        step();
        chk("inh_rel_rq", {15'd0, int_rq}, 16'd1);
        chk("inh_rel_vec", {12'd0, int_addr}, 16'd3);
        pulse_ack(); pulse_done();
        irq_in = 8'h00; steps(2);

        // Level channel re-raises; edge pulse during service is kept
        wr(2'd1, 16'h0002);
        irq_in[1] = 1'b1;
        steps(2);
        chk("lvl_vec", {12'd0, int_addr}, 16'd1);
        pulse_ack();
        irq_in[4] = 1'b1; step(); irq_in[4] = 1'b0; step();
        peek(2'd2, rd); chk("svc_pend", rd, 16'h0012);
        pulse_done();
        step();
        chk("lvl_rearm_rq", {15'd0, int_rq}, 16'd1);
        chk("lvl_rearm_vec", {12'd0, int_addr}, 16'd1);
        pulse_ack();
        irq_in[1] = 1'b0; step();
        pulse_done();
        step();
        chk("edge_later_vec", {12'd0, int_addr}, 16'd4);
        pulse_ack(); pulse_done();
        wr(2'd1, 16'h0000);
        wr(2'd3, 16'hFFFF);
        peek(2'd3, rd); chk("status_ro", rd, 16'h0040);

        // Source high across reset release; W1C loses to a same-edge set
        irq_in = 8'h01;
        do_reset();
        wr(2'd0, 16'h00FF);
        steps(3);
        chk("hi_at_rst", {15'd0, int_rq}, 16'd0);
        irq_in[4] = 1'b1;
        wr(2'd2, 16'h0010);
        peek(2'd2, rd); chk("w1c_vs_set", rd, 16'h0010);
        steps(1);
        chk("w1c_req", {12'd0, int_addr}, 16'd4);

        // Asynchronous reset while requesting
        #2;
        do_reset();
        irq_in = 8'h00;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0)
                irq_in = irq_in ^ 8'(1 << $urandom_range(0, 7));
            int_inhibit = ($urandom_range(0, 4) == 0);
            int_ack     = ($urandom_range(0, 2) == 0);
            int_done    = ($urandom_range(0, 2) == 0);
            cfg_wren    = ($urandom_range(0, 7) == 0);
            cfg_addr    = 2'($urandom_range(0, 3));
            cfg_wdata   = 16'($urandom);
            if (cfg_wren && cfg_addr == 2'd1 && $urandom_range(0, 1) == 0)
                cfg_wdata[7:0] = 8'h00;
            step();
            if ($urandom_range(0, 299) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NUM_CH, default 8, number of interrupt channels, legal 1..16.
REQ-002 Parameter VEC_W, default 4, vector width, SHALL satisfy 2^VEC_W >= NUM_CH.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 irq_in  input  NUM_CH  interrupt sources; bit i = channel i.
REQ-006 int_inhibit  input  1  CPU cannot accept an interrupt; blocks IDLE->REQ.
REQ-007 int_ack  input  1  one-cycle pulse: CPU took the interrupt.
REQ-008 int_done  input  1  one-cycle pulse: CPU finished the service routine (end of interrupt).
REQ-009 cfg_wren  input  1  configuration write strobe.
REQ-010 cfg_addr  input  2  register select: 0 MASK, 1 MODE, 2 PENDING, 3 STATUS.
REQ-011 cfg_wdata  input  16  write data; bits >= NUM_CH ignored.
REQ-012 cfg_rdata  output  16  combinational read of the cfg_addr register; unused bits 0.
REQ-013 int_rq  output  1  registered interrupt request to CPU.
REQ-014 int_addr  output  VEC_W  registered vector of the requested channel.

Function
REQ-015 Edge mode (MODE[i]=0): pending[i] SHALL set on the edge where irq_s[i]=1 and irq_prev[i]=0; irq_s is irq_in (or its synchronised copy); irq_prev is irq_s registered.
REQ-016 Level mode (MODE[i]=1): pending[i] SHALL equal irq_s[i] each cycle; ack and W1C have no lasting effect.
REQ-017 Candidate set = pending & MASK; winner = lowest set index (channel 0 highest priority).
REQ-018 FSM states IDLE, REQ, SERVICE; int_rq=1 only in REQ.
REQ-019 IDLE->REQ when candidate set nonzero and int_inhibit=0; winner latched into int_addr on the same edge.
REQ-020 REQ SHALL hold int_rq and int_addr stable until int_ack, regardless of later MASK, MODE, or pending changes.
REQ-021 REQ->SERVICE on int_ack; in edge mode the same edge clears pending[int_addr].
REQ-022 SERVICE->IDLE on int_done; int_rq SHALL be low for at least one cycle between requests.
REQ-023 int_ack outside REQ and int_done outside SERVICE SHALL be ignored.
REQ-024 Latency: irq_in rise sampled at edge E0 sets pending at E0; int_rq=1 from E1, if IDLE and uninhibited.
REQ-025 PENDING write: write-1-to-clear; a set event on the same edge SHALL win over the clear.
REQ-026 An ack clear and a new edge on the same channel in the same cycle SHALL leave pending set.
REQ-027 MASK=0 channels still accumulate pending; unmasking later SHALL raise a request.
REQ-028 STATUS read: bit0 = (state==SERVICE); bit1 = (state==REQ); bits [VEC_W+3:4] = int_addr.
REQ-029 Writes to STATUS SHALL be ignored.

Reset
REQ-030 On reset: state IDLE, int_rq=0, int_addr=0, pending=0, MASK=0, MODE=0, synchroniser flops 0.
REQ-031 irq_prev SHALL reset to all ones, so a source already high at reset release does not generate an edge.
REQ-032 Reset mid-REQ or mid-SERVICE SHALL drop int_rq asynchronously and discard the latched vector.

Configuration
REQ-033 Macro INT_CTRL_SYNC_EN defined: irq_in passes a two-flop synchroniser before edge detection, adding 2 cycles to REQ-024 latency.
REQ-034 Macro INT_CTRL_SYNC_EN undefined: irq_s = irq_in directly; irq_in SHALL be synchronous to clk.

Verification (NUM_CH=8, VEC_W=4, macro undefined unless noted)
REQ-035 MASK=0xFF; rise on irq_in[5] -> int_rq=1 with int_addr=5 one cycle later; int_ack -> PENDING=0x00; int_done -> IDLE.
REQ-036 irq_in[2] and irq_in[6] rise together -> vector 2 served first; after int_done -> int_rq low for 1+ cycle, then vector 6.
REQ-037 int_inhibit=1 with pending[3] set -> int_rq stays 0; release int_inhibit -> int_rq=1, int_addr=3 next cycle.
REQ-038 Level channel 1 held high through int_done -> request re-raised; edge channel pulse during SERVICE -> pending kept, served after int_done.
REQ-039 irq_in[0] high before reset release -> no request; W1C of 0x10 on the same edge as a channel-4 edge -> PENDING bit4 reads 1.
REQ-040 INT_CTRL_SYNC_EN defined: int_rq rises 3 cycles after irq_in rise; assert reset in REQ -> int_rq=0 immediately.
